easyaxi_slv: RTL and testbench
==============================

# easyaxi_slv

AXI read slave (responder) that terminates the AR/R channels driven by the EasyAXI read master. It accepts up to OST_DEPTH outstanding read requests into an in-order request queue and returns read bursts in acceptance order. Each burst has per-beat address generation for FIXED, INCR and WRAP bursts, an address-derived data pattern and error responses. It sits opposite the master in the S01E05 testbench.

## Interface
Parameters:
- OST_DEPTH, 4: request queue depth; power of 2, at least 1.
- RD_LAT, 0: idle cycles between loading a request and its first R beat; range 0..15.
- ADDR_LIMIT, 'h100: byte addresses at or above this value are decoded as nonexistent.

Ports:
- clk  in  1  clock; everything is sampled on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- axi_slv_arvalid  in  1  AR valid.
- axi_slv_arready  out  1  AR ready; equals ~queue_full, combinational from registered state.
- axi_slv_arid  in  `AXI_ID_W  AR ID.
- axi_slv_araddr  in  `AXI_ADDR_W  AR start byte address.
- axi_slv_arlen  in  `AXI_LEN_W  beats minus 1.
- axi_slv_arsize  in  `AXI_SIZE_W  log2 of bytes per beat.
- axi_slv_arburst  in  `AXI_BURST_W  FIXED / INCR / WRAP.
- axi_slv_rvalid  out  1  R valid; registered.
- axi_slv_rready  in  1  R ready.
- axi_slv_rid  out  `AXI_ID_W  ID of the active burst.
- axi_slv_rdata  out  `AXI_DATA_W  current beat address, zero-extended (truncated if the data bus is narrower).
- axi_slv_rresp  out  `AXI_RESP_W  response of the active burst.
- axi_slv_rlast  out  1  high on the final beat.
- busy  out  1  queue non-empty or FSM not in IDLE.

## Operation
- Request queue: a FIFO of {id, addr, len, size, burst}.
  - Push on arvalid & arready.
  - Pop when the FSM loads the head entry into the active registers.
  - Counts use OST_CNT_W+1 bits; full when count equals OST_DEPTH.
  - A push and a pop in the same cycle leave the count unchanged.
- FSM states are IDLE, WAIT and DATA.
- IDLE
  - If the queue is non-empty: pop the head into the active registers and clear the beat counter.
  - Go to WAIT if RD_LAT > 0, otherwise to DATA.
  - Response is computed at load time:
    - SLVERR if burst == 2'b11.
    - SLVERR if arsize exceeds log2(`AXI_DATA_W/8).
    - SLVERR if burst is WRAP and len is not 1, 3, 7 or 15.
    - DECERR if the start address is at or above ADDR_LIMIT and no SLVERR condition applies.
    - OKAY otherwise.
  - The response is held constant for every beat of the burst.
- WAIT: count RD_LAT cycles, then go to DATA.
- DATA
  - rvalid is high.
  - On each rvalid & rready: advance the beat counter and the address.
  - rlast = (beat counter == active len).
  - On the handshake of the last beat: clear rvalid and go to IDLE.
  - This leaves at least one cycle with rvalid low between bursts.
- Address arithmetic, with bytes = 1 << size and total = (len+1) << size:
  - FIXED: the address does not change.
  - INCR: next = (addr & ~(bytes-1)) + bytes. Carry out of `AXI_ADDR_W is discarded.
  - WRAP: next = (addr & ~(total-1)) | ((addr + bytes) & (total-1)).
  - An illegal WRAP (SLVERR case) advances as INCR.
- rid, rdata, rresp and rlast are stable while rvalid is high and rready is low.
- Reset, including reset asserted mid-burst:
  - Queue is emptied and the FSM returns to IDLE.
  - rvalid, rlast and busy = 0; rid, rdata and rresp = 0.
  - arready = 1 once rst_n has been released.
  - No partial burst resumes after reset.

## Timing
- AR accepted at edge k: the queue is non-empty after k.
- The FSM loads the entry at edge k+1, and moves to DATA when RD_LAT = 0.
- First rvalid appears after edge k+1+RD_LAT.
  - With RD_LAT = 0 and an idle FSM, rvalid is first visible in cycle k+2.
- With rready held at 1, a burst of len+1 beats occupies len+1 consecutive cycles.
  - Next burst's first beat: at the earliest 2+RD_LAT cycles after the last-beat handshake.
- Total acceptance capacity is OST_DEPTH queued requests plus 1 active request.
  - arready falls in the cycle after the push that fills the queue.
  - arready rises in the cycle after the pop that frees a slot.
- AR acceptance continues during R activity; the AR and R channels are independent.

## Test plan
- INCR: id=0, addr 0x00, len 3, size 4B, rready=1.
  - Four beats with rdata 0x00, 0x04, 0x08, 0x0C.
  - rlast only on beat 4; rresp OKAY; first rvalid 2 cycles after AR handshake.
- WRAP: addr 0x34, len 3, size 4B.
  - rdata 0x34, 0x38, 0x3C, 0x30.
- WRAP: addr 0x38, len 7.
  - rdata 0x38, 0x3C, 0x20, 0x24, 0x28, 0x2C, 0x30, 0x34.
- FIXED: addr 0x30, len 7.
  - Eight beats, all with rdata 0x30, rid 3.
- Outstanding and backpressure: master issues ids 0..5 back-to-back with OST_DEPTH=4, and rready toggles 1,0,1,0.
  - arready drops after 5 accepts.
  - Bursts return in id order with no beat lost or duplicated.
  - R payload is held stable while rready is low.
- Errors:
  - burst 2'b11: all beats SLVERR.
  - addr 0x100: all beats DECERR.
  - WRAP with len 2: SLVERR, with INCR addresses.
  - Reset asserted mid-burst: rvalid goes low immediately, the queue is empty, and arready = 1 after reset is released.

Source files
------------

// File: rtl/easyaxi_slv_if.sv
//------------------------------------------------------------------------------
// Module      : easyaxi_slv_if
// Description : AXI read-address / read-data channel bundle between the
//               EasyAXI read master and the easyaxi_slv responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

interface easyaxi_slv_if;
   logic                     axi_slv_arvalid;
   logic                     axi_slv_arready;
   logic [`AXI_ID_W-1:0]     axi_slv_arid;
   logic [`AXI_ADDR_W-1:0]   axi_slv_araddr;
   logic [`AXI_LEN_W-1:0]    axi_slv_arlen;
   logic [`AXI_SIZE_W-1:0]   axi_slv_arsize;
   logic [`AXI_BURST_W-1:0]  axi_slv_arburst;
   logic                     axi_slv_rvalid;
   logic                     axi_slv_rready;
   logic [`AXI_ID_W-1:0]     axi_slv_rid;
   logic [`AXI_DATA_W-1:0]   axi_slv_rdata;
   logic [`AXI_RESP_W-1:0]   axi_slv_rresp;
   logic                     axi_slv_rlast;

   modport master (
      output axi_slv_arvalid, axi_slv_arid, axi_slv_araddr, axi_slv_arlen,
             axi_slv_arsize, axi_slv_arburst, axi_slv_rready,
      input  axi_slv_arready, axi_slv_rvalid, axi_slv_rid, axi_slv_rdata,
             axi_slv_rresp, axi_slv_rlast
   );

   modport slave (
      input  axi_slv_arvalid, axi_slv_arid, axi_slv_araddr, axi_slv_arlen,
             axi_slv_arsize, axi_slv_arburst, axi_slv_rready,
      output axi_slv_arready, axi_slv_rvalid, axi_slv_rid, axi_slv_rdata,
             axi_slv_rresp, axi_slv_rlast
   );
endinterface

`default_nettype wire

// File: rtl/easyaxi_slv.sv
//------------------------------------------------------------------------------
// Module      : easyaxi_slv
// Description : AXI read responder. Queues up to OST_DEPTH read requests in
//               order and returns each burst with the beat address as data,
//               FIXED/INCR/WRAP address stepping and SLVERR/DECERR responses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_slv #(
   parameter int unsigned               OST_DEPTH  = 4,
   parameter int unsigned               RD_LAT     = 0,
   parameter logic [`AXI_ADDR_W-1:0]    ADDR_LIMIT = 'h100
) (
   input  wire                clk,
   input  wire                rst_n,
   easyaxi_slv_if.slave       axi,
   output logic               busy
);

   localparam int unsigned OST_CNT_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
   localparam int unsigned ADDR_W    = `AXI_ADDR_W;
   localparam int unsigned SIZE_W    = `AXI_SIZE_W;

   localparam logic [OST_CNT_W-1:0] PTR_MAX  = OST_CNT_W'(OST_DEPTH - 1);
   localparam logic [OST_CNT_W:0]   CNT_FULL = (OST_CNT_W + 1)'(OST_DEPTH);
   localparam logic [SIZE_W-1:0]    MAX_SIZE = SIZE_W'($clog2(`AXI_DATA_W / 8));
   localparam logic [3:0]           LAT_LAST = 4'((RD_LAT == 0) ? 0 : RD_LAT - 1);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef struct packed {
      logic [`AXI_ID_W-1:0]    id;
      logic [`AXI_ADDR_W-1:0]  addr;
      logic [`AXI_LEN_W-1:0]   len;
      logic [`AXI_SIZE_W-1:0]  size;
      logic [`AXI_BURST_W-1:0] burst;
   } req_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DATA = 2'd2
   } state_t;

   // Request queue
   req_t                  fifo_q [OST_DEPTH];
   logic [OST_CNT_W-1:0]  wr_ptr_q;
   logic [OST_CNT_W-1:0]  rd_ptr_q;
   logic [OST_CNT_W:0]    cnt_q;

   // Active burst
   state_t                  state_q;
   logic [`AXI_ID_W-1:0]    id_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [`AXI_LEN_W-1:0]   len_q;
   logic [SIZE_W-1:0]       size_q;
   logic [1:0]              mode_q;
   logic [1:0]              resp_q;
   logic [`AXI_LEN_W-1:0]   beat_q;
   logic [3:0]              lat_q;
   logic                    rvalid_q;

   logic                    w_push;
   logic                    w_pop;
   req_t                    w_req;
   req_t                    w_head;
   logic                    w_len_ok;
   logic [1:0]              w_resp;
   logic [1:0]              w_mode;
   logic [ADDR_W-1:0]       w_bytes;
   logic [ADDR_W-1:0]       w_total;
   logic [ADDR_W-1:0]       addr_d;

   assign w_req  = '{id: axi.axi_slv_arid, addr: axi.axi_slv_araddr,
                     len: axi.axi_slv_arlen, size: axi.axi_slv_arsize,
                     burst: axi.axi_slv_arburst};
   assign w_head = fifo_q[rd_ptr_q];

   assign axi.axi_slv_arready = (cnt_q != CNT_FULL);
   assign w_push = axi.axi_slv_arvalid & axi.axi_slv_arready;
   assign w_pop  = (state_q == S_IDLE) && (cnt_q != '0);

   assign axi.axi_slv_rvalid = rvalid_q;
   assign axi.axi_slv_rid    = id_q;
   assign axi.axi_slv_rdata  = `AXI_DATA_W'(addr_q);
   assign axi.axi_slv_rresp  = resp_q;
   assign axi.axi_slv_rlast  = rvalid_q & (beat_q == len_q);

   assign busy = (cnt_q != '0) || (state_q != S_IDLE);

   // Decode the response and effective stepping mode of the queue head
   always_comb begin
      w_len_ok = (w_head.len == 8'd1) || (w_head.len == 8'd3) ||
                 (w_head.len == 8'd7) || (w_head.len == 8'd15);
      w_resp   = RESP_OKAY;
      if ((w_head.burst == 2'b11) || (w_head.size > MAX_SIZE) ||
          ((w_head.burst == BURST_WRAP) && !w_len_ok)) begin
         w_resp = RESP_SLVERR;
      end else if (w_head.addr >= ADDR_LIMIT) begin
         w_resp = RESP_DECERR;
      end
      // Anything that is neither FIXED nor a legal WRAP steps as INCR
      w_mode = BURST_INCR;
      if (w_head.burst == BURST_FIXED) begin
         w_mode = BURST_FIXED;
      end else if ((w_head.burst == BURST_WRAP) && w_len_ok) begin
         w_mode = BURST_WRAP;
      end
   end

   // Next beat address of the active burst
   always_comb begin
      w_bytes = ADDR_W'(1) << size_q;
      w_total = (ADDR_W'(len_q) + ADDR_W'(1)) << size_q;
      case (mode_q)
         BURST_FIXED: addr_d = addr_q;
         BURST_WRAP:  addr_d = (addr_q & ~(w_total - ADDR_W'(1))) |
                               ((addr_q + w_bytes) & (w_total - ADDR_W'(1)));
         default:     addr_d = (addr_q & ~(w_bytes - ADDR_W'(1))) + w_bytes;
      endcase
   end

   // Capture accepted requests into queue storage
   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_q[wr_ptr_q] <= w_req;
      end
   end

   // Queue pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Burst sequencer: load head, optional latency, stream beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         mode_q   <= BURST_INCR;
         resp_q   <= RESP_OKAY;
         beat_q   <= '0;
         lat_q    <= '0;
         rvalid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_pop) begin
                  id_q   <= w_head.id;
                  addr_q <= w_head.addr;
                  len_q  <= w_head.len;
                  size_q <= w_head.size;
                  mode_q <= w_mode;
                  resp_q <= w_resp;
                  beat_q <= '0;
                  lat_q  <= '0;
                  if (RD_LAT > 0) begin
                     state_q <= S_WAIT;
                  end else begin
                     state_q  <= S_DATA;
                     rvalid_q <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (lat_q == LAT_LAST) begin
                  state_q  <= S_DATA;
                  rvalid_q <= 1'b1;
               end else begin
                  lat_q <= lat_q + 4'd1;
               end
            end
            S_DATA: begin
               if (rvalid_q && axi.axi_slv_rready) begin
                  if (beat_q == len_q) begin
                     rvalid_q <= 1'b0;
                     state_q  <= S_IDLE;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                     addr_q <= addr_d;
                  end
               end
            end
            default: begin
               state_q  <= S_IDLE;
               rvalid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_easyaxi_slv.sv
//------------------------------------------------------------------------------
// Module      : tb_easyaxi_slv
// Description : Self-checking bench for easyaxi_slv. A request-level model
//               expands every accepted AR into its expected beats; one
//               negedge process compares R against it, and directed tests pin
//               literal beat sequences, latency, backpressure and reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_slv;

   localparam int unsigned OST_DEPTH = 4;
   localparam int unsigned RD_LAT    = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int acc_cnt  = 0;
   int hs_cyc   = 0;

   typedef struct {
      logic [31:0] id;
      logic [31:0] data;
      logic [31:0] resp;
      logic [31:0] last;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] obs_id[$];
   logic [31:0] obs_data[$];
   logic [31:0] obs_resp[$];
   logic [31:0] obs_last[$];
   logic [31:0] exp_l[$];

   easyaxi_slv_if axi ();

   easyaxi_slv #(
      .OST_DEPTH  (OST_DEPTH),
      .RD_LAT     (RD_LAT),
      .ADDR_LIMIT (32'h100)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .axi   (axi),
      .busy  (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_list(string name, logic [31:0] act[$], logic [31:0] exp[$]);
      chk({name, "_count"}, 32'(act.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < act.size(); i++) begin
         chk($sformatf("%s[%0d]", name, i), act[i], exp[i]);
      end
   endtask

   // Expand one request into its beats from the address/response rules
   task automatic model_push(logic [31:0] id, logic [31:0] addr, logic [7:0] len,
                             logic [2:0] size, logic [1:0] burst);
      logic [31:0] bytes, total, a, base, resp;
      bit wrap_ok;
      bytes   = 32'd1 << size;
      total   = (32'(len) + 32'd1) * bytes;
      wrap_ok = (burst == 2'b10) && (len == 1 || len == 3 || len == 7 || len == 15);
      if (burst == 2'b11 || size > 3'd2 || (burst == 2'b10 && !wrap_ok)) resp = 32'd2;
      else if (addr >= 32'h100) resp = 32'd3;
      else resp = 32'd0;
      a = addr;
      for (int b = 0; b <= int'(len); b++) begin
         beat_t e;
         e.id   = id;
         e.data = a;
         e.resp = resp;
         e.last = (b == int'(len)) ? 32'd1 : 32'd0;
         exp_q.push_back(e);
         if (burst == 2'b00) begin
            a = a;
         end else if (wrap_ok) begin
            base = a - (a % total);
            a    = base + ((a - base + bytes) % total);
         end else begin
            a = (a / bytes) * bytes + bytes;
         end
      end
   endtask

   // Monitor AR acceptances and compare every valid R beat with the model
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (axi.axi_slv_arvalid && axi.axi_slv_arready) begin
            acc_cnt++;
            model_push(32'(axi.axi_slv_arid), axi.axi_slv_araddr, axi.axi_slv_arlen,
                       axi.axi_slv_arsize, axi.axi_slv_arburst);
         end
         if (axi.axi_slv_rvalid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL r_unexpected: got beat id %0d data 0x%0h, required no beat",
                        axi.axi_slv_rid, axi.axi_slv_rdata);
            end else begin
               chk("r_id",   32'(axi.axi_slv_rid),   exp_q[0].id);
               chk("r_data", axi.axi_slv_rdata,      exp_q[0].data);
               chk("r_resp", 32'(axi.axi_slv_rresp), exp_q[0].resp);
               chk("r_last", 32'(axi.axi_slv_rlast), exp_q[0].last);
               if (axi.axi_slv_rready) begin
                  obs_id.push_back(32'(axi.axi_slv_rid));
                  obs_data.push_back(axi.axi_slv_rdata);
                  obs_resp.push_back(32'(axi.axi_slv_rresp));
                  obs_last.push_back(32'(axi.axi_slv_rlast));
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic send_ar(logic [3:0] id, logic [31:0] addr, logic [7:0] len,
                          logic [2:0] size, logic [1:0] burst);
      int n = 0;
      axi.axi_slv_arvalid = 1'b1;
      axi.axi_slv_arid    = id;
      axi.axi_slv_araddr  = addr;
      axi.axi_slv_arlen   = len;
      axi.axi_slv_arsize  = size;
      axi.axi_slv_arburst = burst;
      forever begin
         @(negedge clk);
         if (axi.axi_slv_arready) break;
         n++;
         if (n > 200) break;
      end
      if (n > 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL ar_timeout: id %0d not accepted in 200 cycles, required accept", id);
      end
      @(posedge clk);
      #1;
      hs_cyc = cyc;
      axi.axi_slv_arvalid = 1'b0;
   endtask

   task automatic wait_drain(string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_drained"}, 32'(n < 500), 32'd1);
   endtask

   task automatic clr_obs();
      obs_id.delete();
      obs_data.delete();
      obs_resp.delete();
      obs_last.delete();
   endtask

   initial begin
      #100000;
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : stim
      int lat;
      int acc0;
      int seen;
      axi.axi_slv_arvalid = 1'b0;
      axi.axi_slv_arid    = '0;
      axi.axi_slv_araddr  = '0;
      axi.axi_slv_arlen   = '0;
      axi.axi_slv_arsize  = '0;
      axi.axi_slv_arburst = '0;
      axi.axi_slv_rready  = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_arready", 32'(axi.axi_slv_arready), 32'd1);
      chk("rst_rvalid",  32'(axi.axi_slv_rvalid),  32'd0);
      chk("rst_rlast",   32'(axi.axi_slv_rlast),   32'd0);
      chk("rst_busy",    32'(busy),                32'd0);
      chk("rst_rid",     32'(axi.axi_slv_rid),     32'd0);
      chk("rst_rdata",   axi.axi_slv_rdata,        32'd0);
      chk("rst_rresp",   32'(axi.axi_slv_rresp),   32'd0);
      @(posedge clk);
      #1;

      // INCR 4 x 4B from 0x00, first-beat latency
      clr_obs();
      send_ar(4'd0, 32'h00, 8'd3, 3'd2, 2'b01);
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (axi.axi_slv_rvalid) begin
            lat = cyc - hs_cyc;
            break;
         end
      end
      chk("incr_first_rvalid_edges", 32'(lat), 32'd1);
      wait_drain("incr");
      exp_l = '{32'h00, 32'h04, 32'h08, 32'h0C};
      chk_list("incr_data", obs_data, exp_l);
      exp_l = '{32'd0, 32'd0, 32'd0, 32'd1};
      chk_list("incr_last", obs_last, exp_l);
      exp_l = '{32'd0, 32'd0, 32'd0, 32'd0};
      chk_list("incr_resp", obs_resp, exp_l);

      // WRAP 4 x 4B from 0x34
      clr_obs();
      send_ar(4'd1, 32'h34, 8'd3, 3'd2, 2'b10);
      wait_drain("wrap4");
      exp_l = '{32'h34, 32'h38, 32'h3C, 32'h30};
      chk_list("wrap4_data", obs_data, exp_l);

      // WRAP 8 x 4B from 0x38
      clr_obs();
      send_ar(4'd2, 32'h38, 8'd7, 3'd2, 2'b10);
      wait_drain("wrap8");
      exp_l = '{32'h38, 32'h3C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34};
      chk_list("wrap8_data", obs_data, exp_l);

      // WRAP 4 x 2B from 0x06
      clr_obs();
      send_ar(4'd2, 32'h06, 8'd3, 3'd1, 2'b10);
      wait_drain("wrap_hw");
      exp_l = '{32'h06, 32'h00, 32'h02, 32'h04};
      chk_list("wrap_hw_data", obs_data, exp_l);

      // FIXED 8 beats at 0x30, id 3
      clr_obs();
      send_ar(4'd3, 32'h30, 8'd7, 3'd2, 2'b00);
      wait_drain("fixed");
      exp_l = '{32'h30, 32'h30, 32'h30, 32'h30, 32'h30, 32'h30, 32'h30, 32'h30};
      chk_list("fixed_data", obs_data, exp_l);
      exp_l = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3};
      chk_list("fixed_id", obs_id, exp_l);

      // Outstanding requests with R backpressure
      clr_obs();
      axi.axi_slv_rready = 1'b0;
      acc0 = acc_cnt;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               send_ar(4'(i), 32'h40 + 32'(i) * 32'h10, 8'd1, 3'd2, 2'b01);
            end
         end
         begin
            repeat (10) @(posedge clk);
            #1;
            chk("ost_accepts_stalled", 32'(acc_cnt - acc0), 32'd5);
            chk("ost_arready_low", 32'(axi.axi_slv_arready), 32'd0);
            for (int i = 0; i < 60; i++) begin
               axi.axi_slv_rready = (i % 2 == 0);
               @(posedge clk);
               #1;
            end
            axi.axi_slv_rready = 1'b1;
         end
      join
      wait_drain("ost");
      exp_l = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd4, 32'd4, 32'd5, 32'd5};
      chk_list("ost_id", obs_id, exp_l);
      exp_l = '{32'h40, 32'h44, 32'h50, 32'h54, 32'h60, 32'h64,
                32'h70, 32'h74, 32'h80, 32'h84, 32'h90, 32'h94};
      chk_list("ost_data", obs_data, exp_l);

      // Reserved burst type
      clr_obs();
      send_ar(4'd4, 32'h10, 8'd1, 3'd2, 2'b11);
      wait_drain("rsvd");
      exp_l = '{32'd2, 32'd2};
      chk_list("rsvd_resp", obs_resp, exp_l);

      // Address at the decode limit
      clr_obs();
      send_ar(4'd5, 32'h100, 8'd1, 3'd2, 2'b01);
      wait_drain("dec");
      exp_l = '{32'd3, 32'd3};
      chk_list("dec_resp", obs_resp, exp_l);
      exp_l = '{32'h100, 32'h104};
      chk_list("dec_data", obs_data, exp_l);

      // Last word below the decode limit
      clr_obs();
      send_ar(4'd7, 32'hFC, 8'd0, 3'd2, 2'b01);
      wait_drain("below");
      exp_l = '{32'd0};
      chk_list("below_resp", obs_resp, exp_l);

      // Oversized beat
      clr_obs();
      send_ar(4'd8, 32'h00, 8'd0, 3'd3, 2'b01);
      wait_drain("bigsize");
      exp_l = '{32'd2};
      chk_list("bigsize_resp", obs_resp, exp_l);

      // Illegal WRAP length steps as INCR
      clr_obs();
      send_ar(4'd6, 32'h34, 8'd2, 3'd2, 2'b10);
      wait_drain("badwrap");
      exp_l = '{32'd2, 32'd2, 32'd2};
      chk_list("badwrap_resp", obs_resp, exp_l);
      exp_l = '{32'h34, 32'h38, 32'h3C};
      chk_list("badwrap_data", obs_data, exp_l);

      // Reset in the middle of a stalled burst with requests queued
      axi.axi_slv_rready = 1'b0;
      send_ar(4'd9,  32'h00, 8'd15, 3'd2, 2'b01);
      send_ar(4'd10, 32'h20, 8'd1,  3'd2, 2'b01);
      send_ar(4'd11, 32'h40, 8'd1,  3'd2, 2'b01);
      chk("midrst_rvalid_before", 32'(axi.axi_slv_rvalid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_rvalid", 32'(axi.axi_slv_rvalid), 32'd0);
      chk("midrst_rlast",  32'(axi.axi_slv_rlast),  32'd0);
      chk("midrst_busy",   32'(busy),               32'd0);
      chk("midrst_rid",    32'(axi.axi_slv_rid),    32'd0);
      chk("midrst_rdata",  axi.axi_slv_rdata,       32'd0);
      chk("midrst_rresp",  32'(axi.axi_slv_rresp),  32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      axi.axi_slv_rready = 1'b1;
      @(negedge clk);
      chk("midrst_arready_after", 32'(axi.axi_slv_arready), 32'd1);
      chk("midrst_busy_after",    32'(busy),                32'd0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (axi.axi_slv_rvalid || busy) seen++;
      end
      chk("midrst_no_resume", 32'(seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
